result_drain: RTL

Output-side companion to the systolic control front end. It waits for the matrix-multiply done indication and snapshots the flat N×N result bus. It then streams the elements out one per beat over a valid/ready interface, so downstream logic (host bridge, FIFO, next pipeline stage) can consume C without a W·N·N-wide bus.

---
 rtl/result_drain_pkg.sv | 21 ++
 rtl/result_drain_rise_detect.sv | 19 +
 rtl/result_drain.sv | 123 ++++++++++++
 3 files changed

// File: rtl/result_drain_pkg.sv
// Shared types and helpers for the result drain block.
// Build option: RESULT_DRAIN_CKSUM_EN adds a trailing XOR checksum beat.
package result_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CKSUM = 2'd2
    } state_t;

    // Beat index width: must hold 0..N*N (N*N is the checksum beat index).
    function automatic int idx_width(input int n);
        return $clog2(n * n + 1);
    endfunction

    // Low bit of element k on the flat result bus.
    function automatic int elem_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/result_drain_rise_detect.sv
// Rising-edge detector: one-cycle pulse when a level goes from 0 to 1.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    // Track the previous level every cycle, independent of any consumer state.
    always_ff @(posedge clk) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/result_drain.sv
// Snapshots the flat N*N result bus on the rising edge of done and streams
// it out one element per beat over valid/ready.
// Build option: RESULT_DRAIN_CKSUM_EN appends one beat carrying the XOR of
// all elements (o_idx = N*N, o_last on that beat instead of the last element).
module result_drain
    import result_drain_pkg::*;
#(
    parameter int W  = 16,
    parameter int N  = 3,
    localparam int IW = idx_width(N)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_done,
    input  logic [W*N*N-1:0] i_C,
    output logic [W-1:0]     o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [IW-1:0]    o_idx,
    output logic             o_last,
    output logic             o_busy
);

    localparam int NN = N * N;
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
`ifdef RESULT_DRAIN_CKSUM_EN
    localparam logic [IW-1:0] CK_IDX = IW'(NN);
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   next_idx;
    logic [W-1:0]    res_buf [NN];
    logic            start;
    logic            hs;
`ifdef RESULT_DRAIN_CKSUM_EN
    logic [W-1:0]    acc;
`endif

    rise_detect u_rise (
        .clk   (i_clk),
        .rst   (i_rst),
        .level (i_done),
        .rise  (start)
    );

    assign hs       = o_valid & i_ready;
    assign next_idx = idx + IW'(1);
    assign o_busy   = (state != IDLE);

    // Burst FSM; all outputs are registered so o_valid never depends on i_ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
            o_idx   <= '0;
            idx     <= '0;
            for (int k = 0; k < NN; k++) res_buf[k] <= '0;
`ifdef RESULT_DRAIN_CKSUM_EN
            acc     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A start seen outside IDLE is simply never looked at.
                    if (start) begin
                        for (int k = 0; k < NN; k++)
                            res_buf[k] <= i_C[elem_lo(k, W) +: W];
                        o_data  <= i_C[W-1:0];
                        o_idx   <= '0;
                        idx     <= '0;
                        o_valid <= 1'b1;
                        o_last  <= !CK_EN && (NN == 1);
`ifdef RESULT_DRAIN_CKSUM_EN
                        acc     <= '0;
`endif
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        idx <= next_idx;
`ifdef RESULT_DRAIN_CKSUM_EN
                        acc <= acc ^ o_data;
`endif
                        if (idx == LAST_IDX) begin
`ifdef RESULT_DRAIN_CKSUM_EN
                            o_data <= acc ^ o_data;
                            o_idx  <= CK_IDX;
                            o_last <= 1'b1;
                            state  <= CKSUM;
`else
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            state   <= IDLE;
`endif
                        end else begin
                            o_data <= res_buf[next_idx];
                            o_idx  <= next_idx;
                            o_last <= !CK_EN && (next_idx == LAST_IDX);
                        end
                    end
                end
`ifdef RESULT_DRAIN_CKSUM_EN
                CKSUM: begin
                    if (hs) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        state   <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
